// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: fetch FSM encoding and PC constants shared by the IF stage and the branch unit
package if_fetch_unit_pkg;
   typedef enum logic [1:0] {REQ = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} fetch_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction memory req/ack bus
interface if_fetch_unit_if;
   logic imem_req;
   logic [31:0] imem_addr;
   logic imem_ack;
   logic [31:0] imem_rdata;
   modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and instruction fetcher feeding the IF/ID register
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] PC_STEP = DEFAULT_PC_STEP
) (
   input logic clk,
   input logic rst,
   if_fetch_unit_if.master imem,
   input logic freeze,
   input logic branch_taken,
   input logic [31:0] branch_addr,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic fetch_valid
);
   fetch_state_t state, state_n;
   logic [31:0] pc, pc_n, req_addr, hold_instr, hold_n, pc_inc;
   assign pc_inc = pc + PC_STEP;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= REQ;
         pc <= RESET_PC;
         req_addr <= RESET_PC;
         hold_instr <= NOP_INSTR;
      end else begin
         state <= state_n;
         pc <= pc_n;
         req_addr <= state == REQ ? pc : req_addr;
         hold_instr <= hold_n;
      end
   end
   always_comb begin
      state_n = state;
      pc_n = pc;
      hold_n = hold_instr;
      case (state)
         REQ: begin
            if (branch_taken) begin
               pc_n = branch_addr;
               state_n = imem.imem_ack ? REQ : DRAIN;
            end else if (imem.imem_ack && freeze) begin
               hold_n = imem.imem_rdata;
               state_n = HOLD;
            end else if (imem.imem_ack) begin
               pc_n = pc_inc;
            end
         end
         HOLD: begin
            pc_n = branch_taken ? branch_addr : freeze ? pc : pc_inc;
            state_n = branch_taken || !freeze ? REQ : HOLD;
         end
         default: begin
            pc_n = branch_taken ? branch_addr : pc;
            state_n = imem.imem_ack ? REQ : DRAIN;
         end
      endcase
   end
   // DRAIN keeps presenting the abandoned address so the bus address stays stable until ack
   assign imem.imem_req = state != HOLD;
   assign imem.imem_addr = state == DRAIN ? req_addr : pc;
   assign fetch_valid = ((state == REQ && imem.imem_ack) || state == HOLD) && !branch_taken;
   assign instruction_out = !fetch_valid ? NOP_INSTR : state == HOLD ? hold_instr : imem.imem_rdata;
   assign pc_out = fetch_valid ? pc_inc : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
   typedef struct packed {
      logic valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   logic clk = 0, rst = 1;
   logic freeze = 0, branch_taken = 0;
   logic [31:0] branch_addr = 0;
   logic [31:0] pc_out, instruction_out, pc_w, instr_w;
   logic fetch_valid, valid_w, w_ack = 0;
   int n_cmp = 0, n_err = 0;
   exp_t sb[$];
   exp_t mon_e;
   if_fetch_unit_if m ();
   if_fetch_unit_if mw ();
   if_fetch_unit dut (
      .clk(clk), .rst(rst), .imem(m), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .pc_out(pc_out), .instruction_out(instruction_out),
      .fetch_valid(fetch_valid)
   );
   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .imem(mw), .freeze(1'b0), .branch_taken(1'b0),
      .branch_addr(32'h0), .pc_out(pc_w), .instruction_out(instr_w), .fetch_valid(valid_w)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   assign mw.imem_ack = w_ack;
   assign mw.imem_rdata = mem(mw.imem_addr);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // one cycle of stimulus; expected outputs go to the scoreboard, bus address checked directly
   task automatic cyc(input logic ack, input logic fr, input logic br, input logic [31:0] ba,
                      input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] epc, input logic [31:0] ei);
      @(negedge clk);
      m.imem_ack = ack;
      m.imem_rdata = ack ? mem(ea) : 32'hDEAD_BEEF;
      freeze = fr;
      branch_taken = br;
      branch_addr = ba;
      sb.push_back('{ev, epc, ei});
      #1;
      check("imem_req", {31'h0, m.imem_req}, {31'h0, er});
      if (er) check("imem_addr", m.imem_addr, ea);
   endtask
   always @(negedge clk) begin
      #2;
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("fetch_valid", {31'h0, fetch_valid}, {31'h0, mon_e.valid});
         check("pc_out", pc_out, mon_e.pc);
         check("instruction_out", instruction_out, mon_e.instr);
      end
   end
   initial begin
      m.imem_ack = 0;
      m.imem_rdata = 0;
      #12;
      check("rst_req", {31'h0, m.imem_req}, 32'h1);
      check("rst_addr", m.imem_addr, 32'h0);
      check("rst_valid", {31'h0, fetch_valid}, 32'h0);
      check("rst_pc", pc_out, 32'h0);
      check("rst_instr", instruction_out, 32'h0);
      check("w_rst_addr", mw.imem_addr, 32'hFFFF_FFFC);
      rst = 0;
      @(negedge clk);
      w_ack = 1;
      #1;
      check("w_addr0", mw.imem_addr, 32'hFFFF_FFFC);
      check("w_pc0", pc_w, 32'h0);
      check("w_valid0", {31'h0, valid_w}, 32'h1);
      check("w_instr0", instr_w, mem(32'hFFFF_FFFC));
      // sequential single-cycle fetch, then freeze at pc=8 for three cycles
      cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h4, mem(32'h0));
      check("w_addr1", mw.imem_addr, 32'h0);
      check("w_pc1", pc_w, 32'h4);
      cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h8, mem(32'h4));
      cyc(1, 1, 0, 0, 1, 32'h8, 1, 32'hC, mem(32'h8));
      cyc(0, 1, 0, 0, 0, 32'h0, 1, 32'hC, mem(32'h8));
      cyc(0, 1, 0, 0, 0, 32'h0, 1, 32'hC, mem(32'h8));
      cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'hC, mem(32'h8));
      cyc(0, 0, 0, 0, 1, 32'hC, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'hC, 1, 32'h10, mem(32'hC));
      // branch during a 3-cycle request at 16: drain then redirect to 0x100
      cyc(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, 32'h0);
      cyc(0, 0, 1, 32'h100, 1, 32'h10, 0, 32'h0, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'h10, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'h100, 1, 32'h104, mem(32'h100));
      // ack with branch discards; branch+freeze with ack at 20 goes to 0x40 without HOLD
      cyc(1, 0, 1, 32'h14, 1, 32'h104, 0, 32'h0, 32'h0);
      cyc(1, 1, 1, 32'h40, 1, 32'h14, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'h40, 1, 32'h44, mem(32'h40));
      // branch out of HOLD
      cyc(1, 1, 0, 0, 1, 32'h44, 1, 32'h48, mem(32'h44));
      cyc(0, 1, 1, 32'h200, 0, 32'h0, 0, 32'h0, 32'h0);
      cyc(1, 0, 0, 0, 1, 32'h200, 1, 32'h204, mem(32'h200));
      // last branch wins in DRAIN, then async reset while draining
      cyc(0, 0, 1, 32'h300, 1, 32'h204, 0, 32'h0, 32'h0);
      cyc(0, 0, 1, 32'h400, 1, 32'h204, 0, 32'h0, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'h204, 0, 32'h0, 32'h0);
      @(posedge clk);
      #2;
      rst = 1;
      #1;
      check("arst_req", {31'h0, m.imem_req}, 32'h1);
      check("arst_addr", m.imem_addr, 32'h0);
      check("arst_valid", {31'h0, fetch_valid}, 32'h0);
      rst = 0;
      cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h4, mem(32'h0));
      cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h8, mem(32'h4));
      repeat (2) @(negedge clk);
      check("sb_empty", sb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Producer side of the IF/ID pipeline register. It owns the program counter and fetches instructions from instruction memory over a req/ack handshake with variable latency. Each cycle it presents either a valid pc+4/instruction pair or a zero bubble to the IF/ID register. It honours freeze from the hazard unit and redirects to a branch target from EXE.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
freeze  input  1  hazard stall; the IF/ID register will not capture this cycle
branch_taken  input  1  redirect request from EXE; has priority over freeze
branch_addr  input  32  redirect target
imem_req  output  1  instruction memory request
imem_addr  output  32  request address; stable while imem_req=1 until ack
imem_ack  input  1  one-cycle strobe; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
pc_out  output  32  fetched address + PC_STEP; feeds IF/ID pcIn
instruction_out  output  32  fetched instruction; feeds IF/ID instructionIn
fetch_valid  output  1  pc_out/instruction_out carry a real instruction

Behaviour:
- Clock and reset: clk, rising edge; rst asynchronous, active-high.
- Registers: pc, req_addr, hold_instr, state ∈ {REQ, HOLD, DRAIN}.
- Reset values: pc=RESET_PC, req_addr=RESET_PC, hold_instr=0, state=REQ.
- Reset output values: imem_req=1, imem_addr=RESET_PC, fetch_valid=0, pc_out=0, instruction_out=0.
- A reset that asserts mid-request abandons that request. The memory must tolerate this.
- Bubble rule: when fetch_valid=0, pc_out=0 and instruction_out=0. This is the same value the IF/ID register loads on flush.
- REQ state:
  - Drives imem_req=1 and imem_addr=pc. req_addr is loaded with pc on entry.
  - If imem_ack=1, outputs are combinational from the ack path: fetch_valid=1, instruction_out=imem_rdata, pc_out=pc+PC_STEP. There is zero added latency; IF/ID captures on the same edge.
  - ack & branch_taken: the fetched word is discarded and fetch_valid is forced to 0. Then pc<=branch_addr and the state stays REQ.
  - ack & !branch & freeze: hold_instr<=imem_rdata, next state HOLD, pc unchanged.
  - ack & !branch & !freeze: pc<=pc+PC_STEP, state stays REQ. This gives back-to-back requests, so with single-cycle memory the unit delivers one instruction per cycle.
  - No ack & branch_taken: pc<=branch_addr, next state DRAIN, because the outstanding request must complete.
  - No ack & !branch: wait. freeze is irrelevant here.
- HOLD state:
  - imem_req=0. Outputs: fetch_valid=1, instruction_out=hold_instr, pc_out=pc+PC_STEP.
  - branch_taken: fetch_valid forced to 0, pc<=branch_addr, next state REQ.
  - else !freeze: pc<=pc+PC_STEP, next state REQ.
  - else (freeze): stay HOLD.
- DRAIN state:
  - imem_req=1 and imem_addr=req_addr (the old address is kept to honour the stable-address rule). fetch_valid=0.
  - On ack: the data is discarded and the next state is REQ with the already-redirected pc.
  - A new branch_taken while in DRAIN: pc<=branch_addr and the state stays DRAIN. Last branch wins.
- Arithmetic: pc+PC_STEP is 32-bit and wraps modulo 2^32, with no overflow flag.
- Simultaneous branch_taken and freeze: branch wins in every state.

Decomposition:
- Shared package:
  - fetch state encoding: REQ=2'd0, HOLD=2'd1, DRAIN=2'd2
  - NOP_INSTR = 32'h0
  - default PC_STEP and RESET_PC constants, reused by the IF stage and the branch unit
- No sub-module is needed; the FSM, pc register and hold buffer fit in one module. If a fetch-side register is split out later, it should be named fetch_hold_buf.

Test Plan:
- Single-cycle memory (ack the cycle after req rises, held thereafter), no freeze/branch, reset release -> imem_addr 0,4,8,… on consecutive cycles; pc_out 4,8,12,…; fetch_valid=1 every cycle from the first ack.
- Ack at pc=8 with freeze=1 for 3 cycles -> state HOLD; imem_req=0; instruction_out steady at hold_instr; pc_out=12. When freeze drops, next imem_addr=12.
- 3-cycle latency memory, branch_taken to 32'h100 one cycle after req at addr 16 -> imem_addr stays 16 until ack; that data is dropped (fetch_valid=0); next imem_addr=32'h100.
- branch_taken and freeze both asserted with ack at addr 20, branch_addr 32'h40 -> fetch_valid=0, no HOLD entered, next imem_addr=32'h40.
- RESET_PC=32'hFFFF_FFFC sequential fetch -> imem_addr FFFF_FFFC then 0000_0000; pc_out=0 for the first fetch.
- rst asserted while a request is outstanding in DRAIN -> outputs reset asynchronously; after release imem_addr=RESET_PC and state REQ.
